// File: rtl/cp0_unit.sv
// Coprocessor-0 at the M stage: holds SR, Cause, EPC and PRId, decides whether
// an interrupt or exception is taken this cycle and records the victim state.
module cp0_unit #(
   parameter logic [31:0] PRID_VAL  = 32'h2023_0007,
   parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] CP0In,
   output logic [31:0] CP0Out,
   input  logic        En,
   input  logic [31:0] VPC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic [31:0] EPCOut,
   output logic [31:0] HandlerPC,
   output logic        Req
);

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_q;
   logic [4:0]  exc_q, exc_d;
   logic [31:0] epc_q, epc_d;

   logic        int_req;
   logic        exc_req;
   logic [31:0] victim_pc;
   logic [31:0] sr_val;
   logic [31:0] cause_val;

   assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
   assign exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
   // Gated by reset so nothing is requested while the registers are held clear.
   assign Req     = reset & (int_req | exc_req);

   assign victim_pc = BDIn ? (VPC - 32'd4) : VPC;

   always_comb begin
      im_d  = im_q;
      exl_d = exl_q;
      ie_d  = ie_q;
      bd_d  = bd_q;
      exc_d = exc_q;
      epc_d = epc_q;
      if (Req) begin
         // The M-stage instruction is flushed, so its mtc0/eret side effects are dropped.
         exl_d = 1'b1;
         bd_d  = BDIn;
         exc_d = int_req ? 5'd0 : ExcCodeIn;
         epc_d = victim_pc & ~32'd3;
      end else begin
         if (En && A2 == REG_SR) begin
            im_d  = CP0In[15:10];
            exl_d = CP0In[1];
            ie_d  = CP0In[0];
         end
         if (En && A2 == REG_EPC) begin
            epc_d = CP0In;
         end
         if (EXLClr) begin
            exl_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im_q  <= 6'd0;
         exl_q <= 1'b0;
         ie_q  <= 1'b0;
         bd_q  <= 1'b0;
         ip_q  <= 6'd0;
         exc_q <= 5'd0;
         epc_q <= 32'd0;
      end else begin
         im_q  <= im_d;
         exl_q <= exl_d;
         ie_q  <= ie_d;
         bd_q  <= bd_d;
         ip_q  <= HWInt;
         exc_q <= exc_d;
         epc_q <= epc_d;
      end
   end

   assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
   assign cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};

   always_comb begin
      case (A1)
         REG_SR:    CP0Out = sr_val;
         REG_CAUSE: CP0Out = cause_val;
         REG_EPC:   CP0Out = epc_q;
         REG_PRID:  CP0Out = PRID_VAL;
         default:   CP0Out = 32'd0;
      endcase
   end

   assign EPCOut    = epc_q;
   assign HandlerPC = EXC_ENTRY;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed test of cp0_unit: reset, mtc0/mfc0, exception and interrupt entry,
// priority, eret and asynchronous reset during handler state.
module tb_cp0_unit;

   logic        clk;
   logic        reset;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] CP0In;
   logic [31:0] CP0Out;
   logic        En;
   logic [31:0] VPC;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic [31:0] EPCOut;
   logic [31:0] HandlerPC;
   logic        Req;

   int n_checks = 0;
   int n_fail   = 0;

   cp0_unit dut (
      .clk       (clk),
      .reset     (reset),
      .A1        (A1),
      .A2        (A2),
      .CP0In     (CP0In),
      .CP0Out    (CP0Out),
      .En        (En),
      .VPC       (VPC),
      .BDIn      (BDIn),
      .ExcCodeIn (ExcCodeIn),
      .HWInt     (HWInt),
      .EXLClr    (EXLClr),
      .EPCOut    (EPCOut),
      .HandlerPC (HandlerPC),
      .Req       (Req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
      A1 = a;
      #1;
      check(tag, CP0Out, exp);
   endtask

   initial begin
      reset = 1'b0; A1 = 5'd0; A2 = 5'd0; CP0In = 32'd0; En = 1'b0;
      VPC = 32'd0; BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
      step(); step();
      reset = 1'b1;
      step();
      $display("reset release");
      rd("rst_sr", 5'd12, 32'h0000_0000);
      rd("rst_cause", 5'd13, 32'h0000_0000);
      rd("rst_epc", 5'd14, 32'h0000_0000);
      rd("rst_prid", 5'd15, 32'h2023_0007);
      rd("unimpl_0", 5'd0, 32'h0000_0000);
      check("rst_req", {31'd0, Req}, 32'd0);
      check("handler_pc", HandlerPC, 32'h0000_4180);

      $display("mtc0 SR <= ffffffff");
      En = 1'b1; A2 = 5'd12; CP0In = 32'hFFFF_FFFF;
      rd("no_writethrough", 5'd12, 32'h0000_0000);
      step();
      rd("sr_masked", 5'd12, 32'h0000_FC03);
      $display("mtc0 Cause/PRId ignored");
      A2 = 5'd13; step();
      rd("cause_unwritable", 5'd13, 32'h0000_0000);
      A2 = 5'd15; step();
      rd("prid_unwritable", 5'd15, 32'h2023_0007);
      A2 = 5'd12; CP0In = 32'd0; step();
      En = 1'b0;
      rd("sr_cleared", 5'd12, 32'h0000_0000);

      $display("delay-slot AdEL at 00003008");
      ExcCodeIn = 5'd4; VPC = 32'h0000_3008; BDIn = 1'b1;
      #1 check("exc_req", {31'd0, Req}, 32'd1);
      step();
      ExcCodeIn = 5'd0; BDIn = 1'b0;
      rd("exc_epc", 5'd14, 32'h0000_3004);
      check("exc_epcout", EPCOut, 32'h0000_3004);
      rd("exc_cause", 5'd13, 32'h8000_0010);
      rd("exc_sr_exl", 5'd12, 32'h0000_0002);
      $display("nested exception blocked by EXL");
      ExcCodeIn = 5'd10; VPC = 32'h0000_300C;
      #1 check("nested_req", {31'd0, Req}, 32'd0);
      step();
      ExcCodeIn = 5'd0;
      check("nested_epc", EPCOut, 32'h0000_3004);
      rd("nested_cause", 5'd13, 32'h8000_0010);

      $display("eret");
      EXLClr = 1'b1; step(); EXLClr = 1'b0;
      rd("eret_sr", 5'd12, 32'h0000_0000);
      check("eret_epc", EPCOut, 32'h0000_3004);

      $display("interrupt HWInt[0] with SR=401");
      En = 1'b1; A2 = 5'd12; CP0In = 32'h0000_0401; step(); En = 1'b0;
      HWInt = 6'b000001; VPC = 32'h0000_5000;
      #1 check("int_req", {31'd0, Req}, 32'd1);
      step();
      rd("int_cause", 5'd13, 32'h0000_0400);
      rd("int_epc", 5'd14, 32'h0000_5000);
      rd("int_sr", 5'd12, 32'h0000_0403);
      check("int_blocked", {31'd0, Req}, 32'd0);
      EXLClr = 1'b1; step(); EXLClr = 1'b0;
      rd("int_eret_sr", 5'd12, 32'h0000_0401);
      check("int_pending_again", {31'd0, Req}, 32'd1);
      HWInt = 6'd0;
      #1 check("int_dropped", {31'd0, Req}, 32'd0);
      En = 1'b1; A2 = 5'd12; CP0In = 32'h0000_0400; step(); En = 1'b0;
      $display("interrupt masked by IE=0");
      HWInt = 6'b000001;
      #1 check("ie0_req", {31'd0, Req}, 32'd0);
      step();
      rd("ie0_ip", 5'd13, 32'h0000_0400);

      $display("priority: interrupt + exc 8 + mtc0 EPC");
      En = 1'b1; A2 = 5'd12; CP0In = 32'h0000_0401; step();
      A2 = 5'd14; CP0In = 32'hDEAD_BEEF; ExcCodeIn = 5'd8; VPC = 32'h0000_6004;
      #1 check("prio_req", {31'd0, Req}, 32'd1);
      step();
      En = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0;
      rd("prio_cause", 5'd13, 32'h0000_0400);
      rd("prio_epc", 5'd14, 32'h0000_6004);
      rd("prio_sr", 5'd12, 32'h0000_0403);

      $display("eret with mtc0 SR <= 403");
      En = 1'b1; A2 = 5'd12; CP0In = 32'h0000_0403; EXLClr = 1'b1;
      step();
      En = 1'b0; EXLClr = 1'b0;
      rd("eret_mtc0_sr", 5'd12, 32'h0000_0401);
      check("eret_mtc0_epc", EPCOut, 32'h0000_6004);

      $display("mtc0 EPC <= 00001235");
      En = 1'b1; A2 = 5'd14; CP0In = 32'h0000_1235; step(); En = 1'b0;
      rd("mtc0_epc", 5'd14, 32'h0000_1235);

      $display("unaligned victim 00007003, no delay slot");
      ExcCodeIn = 5'd1; VPC = 32'h0000_7003;
      step();
      rd("align_epc", 5'd14, 32'h0000_7000);
      rd("align_cause", 5'd13, 32'h0000_0004);
      rd("align_sr", 5'd12, 32'h0000_0403);

      $display("async reset while EXL=1");
      #2 reset = 1'b0;
      #1;
      rd("arst_sr", 5'd12, 32'h0000_0000);
      check("arst_epc", EPCOut, 32'h0000_0000);
      check("arst_req", {31'd0, Req}, 32'd0);
      step();
      reset = 1'b1; ExcCodeIn = 5'd0;
      rd("arst_cause", 5'd13, 32'h0000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 for the P7 five-stage MIPS pipeline, placed at the M stage.
- It is the responding end of the exception signalling that the D-stage controller starts: it takes the accumulated exception code, branch-delay flag, victim PC, hardware interrupt lines, mtc0 writes and eret.
- It holds SR, Cause, EPC and PRId.
- It raises a single request (Req) that flushes the pipeline and redirects fetch to the handler. It supplies EPC for eret.

Parameters:
- PRID_VAL, 32'h2023_0007, constant value returned on reads of PRId (register 15).
- EXC_ENTRY, 32'h0000_4180, handler address driven on HandlerPC.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- A1  input  5  mfc0 read register number.
- A2  input  5  mtc0 write register number.
- CP0In  input  32  mtc0 write data.
- CP0Out  output  32  mfc0 read data, combinational.
- En  input  1  mtc0 write enable (M-stage mtc0).
- VPC  input  32  PC of the M-stage instruction (victim).
- BDIn  input  1  M-stage instruction is in a delay slot.
- ExcCodeIn  input  5  accumulated exception code; 0 means none.
- HWInt  input  6  external interrupt lines; [2] is the timer and [0..1] are the others.
- EXLClr  input  1  eret in M; clears EXL.
- EPCOut  output  32  current EPC register value.
- HandlerPC  output  32  constant EXC_ENTRY.
- Req  output  1  take exception/interrupt this cycle (combinational).

Behaviour:

Register layout:
- SR(12): IM=[15:10], EXL=[1], IE=[0]. All other bits read as 0.
- Cause(13): BD=[31], IP=[15:10], ExcCode=[6:2]. All other bits read as 0.
- EPC(14): full 32 bits.
- PRId(15): PRID_VAL.

Reset:
- reset low clears SR, Cause and EPC to 0 immediately, independent of clk, including in the middle of handler entry.
- While reset is low, Req=0 and EPCOut=0.

Request logic (combinational):
- IntReq = (|(HWInt & IM)) & IE & !EXL.
- ExcReq = (ExcCodeIn != 0) & !EXL.
- Req = IntReq | ExcReq.
- Interrupts take priority over exceptions.

Cause.IP:
- Updated every clock edge from HWInt, whatever the other state.

On a clock edge with Req=1:
- EXL <= 1.
- Cause.BD <= BDIn.
- Cause.ExcCode <= 0 if IntReq, else ExcCodeIn.
- EPC <= BDIn ? (VPC - 4) : VPC, with bits [1:0] forced to 00.
- The mtc0 write and EXLClr in the same cycle are discarded, because the instruction is being flushed.

On a clock edge with Req=0:
- If En and A2==12: SR <= CP0In masked to the implemented bits.
- If En and A2==14: EPC <= CP0In.
- Writes to Cause, PRId or any other number are ignored.
- If EXLClr: EXL <= 0.
- If both En to SR and EXLClr occur, EXLClr wins for the EXL bit; the other SR bits take CP0In.

Reads:
- CP0Out = register selected by A1, using pre-edge values (no write-through).
- Unimplemented numbers read 0.

Other outputs:
- EPCOut = EPC register, not bypassed.
- While EXL=1, no nested request occurs, even with a nonzero ExcCodeIn or an enabled interrupt pending.

Test Plan:
- Reset: release reset → CP0Out for A1=12,13,14 reads 0, A1=15 reads 32'h2023_0007, Req=0. Assert reset while EXL=1 → SR reads 0 in the same cycle.
- mtc0: En=1, A2=12, CP0In=32'hFFFF_FFFF → SR reads 32'h0000_FC03. Then A2=13 with any data → Cause unchanged.
- Delay-slot exception: ExcCodeIn=4 (AdEL), VPC=32'h0000_3008, BDIn=1 → Req=1. Next cycle EPC=32'h0000_3004, Cause=32'h8000_0010, EXL=1. Repeat ExcCodeIn=10 → Req=0.
- Interrupt: SR=32'h0000_0401, HWInt=6'b000001 → Req=1, ExcCode=0, EPC=VPC. With IE=0 → Req=0, but Cause.IP still shows 6'b000001.
- Priority: HWInt enabled and ExcCodeIn=8 together → ExcCode=0. Req together with En to EPC → EPC=victim PC, not CP0In.
- eret: EXL=1, EXLClr=1 → EXL=0 next cycle and EPCOut unchanged. EXLClr together with En to SR with CP0In=32'h403 → SR=32'h401.
